rf_stream_reader: RTL and testbench
===================================

Name: rf_stream_reader

Overview:
- Read-side sequencer for the 16-entry latch register file.
- On `start_i` it walks a contiguous address range through the file's combinational read port and emits each word as a valid/ready stream beat.
- Sits between the register file and downstream consumers (decoder/accumulator). It replaces ad-hoc `raddr` muxing with a back-pressure-aware burst reader.

Parameters:
- `ADDR_WIDTH`, 4, register file address width; `NUM_WORDS = 2**ADDR_WIDTH`.
- `DataWidth`, 16, word width.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  starts a burst; sampled only in IDLE.
- `base_addr_i`  in  ADDR_WIDTH  first address of the burst.
- `len_i`  in  ADDR_WIDTH+1  number of words; legal range 0..NUM_WORDS.
- `busy_o`  out  1  high while not IDLE.
- `done_o`  out  1  single-cycle pulse after the last beat handshakes, or after a zero-length burst.
- `raddr_o`  out  ADDR_WIDTH  to register file `raddr_a_i`.
- `rdata_i`  in  DataWidth  from register file `rdata_a_o`; combinational.
- `we_i`  in  1  snoop of register file `we_a_i`; used only by the optional feature.
- `waddr_i`  in  ADDR_WIDTH  snoop of register file `waddr_a_i`.
- `valid_o`  out  1  output beat valid.
- `ready_i`  in  1  consumer ready.
- `data_o`  out  DataWidth  beat data.
- `addr_o`  out  ADDR_WIDTH  address the beat was read from.
- `last_o`  out  1  marks the final beat of the burst.

Behaviour:
- Reset values:
  - FSM = IDLE.
  - `busy_o`, `done_o`, `valid_o`, `last_o` = 0.
  - `raddr_o`, `data_o`, `addr_o` = 0.
  - Internal address and remaining count = 0.
  - Reset mid-burst aborts immediately; no `done_o`.
- FSM states: IDLE, READ, DRAIN.
  - IDLE, `start_i`=1, `len_i`≠0: latch `base_addr_i` into the address counter and `len_i` into the remaining count; go to READ.
  - IDLE, `start_i`=1, `len_i`=0: `done_o` pulses the next cycle; stay IDLE.
  - READ: `raddr_o` = address counter. Capture occurs when the output register is empty or `ready_i`=1 in that cycle.
    - On capture: `data_o` <= `rdata_i`, `addr_o` <= `raddr_o`, `valid_o` <= 1.
    - On capture: `last_o` <= (remaining == 1); address += 1 modulo NUM_WORDS; remaining -= 1.
    - Capture of the last word moves to DRAIN.
  - DRAIN: hold until the `last_o` beat handshakes (`valid_o` && `ready_i`). Then `valid_o` = 0 and `done_o` pulses one cycle together with the return to IDLE.
- Latency: `start_i` at cycle N gives `raddr_o` = base in N+1 and the first `valid_o` in N+2.
- Throughput: 1 beat/cycle with `ready_i` held high. A burst of L words completes with `done_o` at N+L+2.
- Handshake rules:
  - Once `valid_o` is asserted, `data_o`, `addr_o` and `last_o` stay stable until the handshake.
  - `valid_o` never depends combinationally on `ready_i`.
- While stalled (output full, `ready_i`=0), `raddr_o` holds. No word is skipped or duplicated.
- Wrap-around: with base 14 and len 4, the read order is 14, 15, 0, 1.
- `len_i` = NUM_WORDS reads every entry once.
- `start_i` while busy is ignored.
- `len_i` > NUM_WORDS is clamped to NUM_WORDS.
- `raddr_o` in IDLE holds its last value; there are no combinational paths from `start_i`.

Optional Feature:
- Macro: `RF_READER_HAZARD_STALL_EN`.
- When defined:
  - In READ, if `we_i`=1 and `waddr_i` == `raddr_o` (a write to the word being read, committed by the file one cycle later), capture is suppressed for that cycle and the next cycle.
  - The same address is re-read after the write lands, so consumers always see post-write data.
  - `we_i`/`waddr_i` are otherwise unused.
- When undefined:
  - No stall; `rdata_i` is captured as-is.
  - `we_i`/`waddr_i` are unused and lint-waived.

Decomposition:
- Package `rf_reader_pkg`:
  - `rf_reader_state_e` enum (IDLE, READ, DRAIN).
  - Default `ADDR_WIDTH`/`DataWidth` localparams.
- Sub-module `rf_reader_out_reg`:
  - Single-entry valid/ready output register holding `data_o`, `addr_o` and `last_o`.
  - Exposes a capture-enable signal.
- FSM and counters stay in the top module.

Test Plan:
- Preload word i = 0x1000+i; base=3, len=4, `ready_i`=1 -> beats 0x1003..0x1006 on consecutive cycles, `last_o` on 0x1006, `done_o` at N+6.
- base=14, len=4 -> addrs 14, 15, 0, 1 with data 0x100E, 0x100F, 0x1000, 0x1001.
- base=0, len=16, `ready_i` toggled randomly -> exactly 16 in-order beats; data stable during every stall; one `done_o`.
- `len_i`=0 -> no `valid_o`, `done_o` pulse at N+1; `start_i` pulsed mid-burst -> ignored, beat count unchanged.
- Assert `rst_i` after 2 of 8 beats -> all outputs 0 next edge, no `done_o`; a new burst after release runs cleanly.
- With `RF_READER_HAZARD_STALL_EN`, write 0xBEEF to address 5 in the cycle `raddr_o`=5 -> the beat for addr 5 carries 0xBEEF. Without the macro -> it carries the old value 0x1005.

Source files
------------

// File: rtl/rf_reader_pkg.sv
// Shared types and defaults for the register-file stream reader.
package rf_reader_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rf_reader_state_e;

endpackage

// File: rtl/rf_reader_out_reg.sv
// Single-entry valid/ready output register for the stream reader.
// The cap_ok output indicates that the slot can accept a new word this cycle.
module rf_reader_out_reg
  import rf_reader_pkg::*;
#(
  parameter int AW = ADDR_WIDTH_DEF,
  parameter int DW = DATA_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] ain,
  input  logic          lin,
  input  logic          ready,
  output logic          cap_ok,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [AW-1:0] addr,
  output logic          last
);

  // The slot is free when it is empty or its beat is leaving this cycle.
  assign cap_ok = !valid || ready;

  // Load a new beat, or retire the current one on handshake; payload holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      addr  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
      addr  <= ain;
      last  <= lin;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_stream_reader.sv
// Burst reader that walks a contiguous (wrapping) address range of the
// 16-entry latch register file and streams the words out over valid/ready.
// Optional feature: define RF_READER_HAZARD_STALL_EN to stall capture around
// a write to the word currently being read, so the beat carries post-write data.
module rf_stream_reader
  import rf_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DataWidth  = DATA_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] raddr_o,
  input  logic [DataWidth-1:0]  rdata_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DataWidth-1:0]  data_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] NUM_WORDS = LW'(2**ADDR_WIDTH);

  rf_reader_state_e state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LW-1:0]         rem_q;
  logic [LW-1:0]         len_c;
  logic                  cap_ok;
  logic                  cap;
  logic                  stall;

  // Oversized lengths read the whole file exactly once.
  assign len_c   = (len_i > NUM_WORDS) ? NUM_WORDS : len_i;
  assign raddr_o = addr_q;
  assign busy_o  = (state != IDLE);

`ifdef RF_READER_HAZARD_STALL_EN
  logic hit;
  logic hz_q;
  // The file commits a write one cycle after we_i, so skip this cycle and the
  // next, then re-read the same address.
  assign hit   = (state == READ) && we_i && (waddr_i == addr_q);
  assign stall = hit || hz_q;

  // Remember a hit so the cycle after it is also skipped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) hz_q <= 1'b0;
    else       hz_q <= hit;
  end
`else
  logic unused_snoop;
  assign unused_snoop = ^{we_i, waddr_i};
  assign stall        = 1'b0;
`endif

  assign cap = (state == READ) && cap_ok && !stall;

  // Burst sequencing: address walk, remaining count and done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      addr_q <= '0;
      rem_q  <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (len_c == '0) begin
              done_o <= 1'b1;
            end else begin
              addr_q <= base_addr_i;
              rem_q  <= len_c;
              state  <= READ;
            end
          end
        end
        READ: begin
          if (cap) begin
            addr_q <= addr_q + 1'b1;
            rem_q  <= rem_q - 1'b1;
            if (rem_q == LW'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (valid_o && ready_i) begin
            state  <= IDLE;
            done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rf_reader_out_reg #(
    .AW (ADDR_WIDTH),
    .DW (DataWidth)
  ) u_out (
    .clk    (clk_i),
    .rst    (rst_i),
    .load   (cap),
    .din    (rdata_i),
    .ain    (addr_q),
    .lin    (rem_q == LW'(1)),
    .ready  (ready_i),
    .cap_ok (cap_ok),
    .valid  (valid_o),
    .data   (data_o),
    .addr   (addr_o),
    .last   (last_o)
  );

endmodule

// File: tb/tb_rf_stream_reader.sv
// Self-checking bench for rf_stream_reader with a behavioural register file.
module tb_rf_stream_reader;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, valid, last;
  logic [AW-1:0] raddr, addr;
  logic [DW-1:0] rdata, data;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          ready = 1'b0;

  logic [DW-1:0] mem [NW];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Register file: combinational read, write lands at the next edge.
  assign rdata = mem[raddr];
  always @(posedge clk) if (we) mem[waddr] <= wdata;

  rf_stream_reader dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .base_addr_i (base_addr),
    .len_i       (len),
    .busy_o      (busy),
    .done_o      (done),
    .raddr_o     (raddr),
    .rdata_i     (rdata),
    .we_i        (we),
    .waddr_i     (waddr),
    .valid_o     (valid),
    .ready_i     (ready),
    .data_o      (data),
    .addr_o      (addr),
    .last_o      (last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One burst: expected beats are mem[(base+i) mod 16] for i < min(len,16).
  task automatic run_burst(input int b, input int l, input bit rnd, input bit poke,
                           input bit hz, input bit chk_time);
    logic [AW-1:0] exp_a [$];
    logic [DW-1:0] exp_d [$];
    int n, cyc, got, dcnt, dcyc;
    bit held, fin, hz_done;
    logic [DW-1:0] hd;
    logic [AW-1:0] ha;
    logic hl;
    n = (l > NW) ? NW : l;
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = AW'((b + i) % NW);
      exp_a.push_back(a);
`ifdef RF_READER_HAZARD_STALL_EN
      exp_d.push_back((hz && a == 5) ? 16'hBEEF : mem[a]);
`else
      exp_d.push_back(mem[a]);
`endif
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(b); len = (AW+1)'(l);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; got = 0; dcnt = 0; dcyc = 0; held = 0; fin = 0; hz_done = 0;
    while (!fin && cyc < 200) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hz && !hz_done && busy && raddr == 5) begin
        we = 1'b1; waddr = 4'd5; wdata = 16'hBEEF; hz_done = 1;
      end else begin
        we = 1'b0;
      end
      @(negedge clk);
      if (cyc == 1) chk("busy_after_start", busy, (n != 0));
      if (valid) begin
        if (held) begin
          chk("stall_data", data, hd);
          chk("stall_addr", addr, ha);
          chk("stall_last", last, hl);
        end
        if (ready) begin
          if (got < n) begin
            chk("beat_addr", addr, exp_a[got]);
            chk("beat_data", data, exp_d[got]);
            chk("beat_last", last, (got == n - 1));
          end else begin
            chk("beat_count_overrun", got + 1, n);
          end
          held = 0;
          got++;
        end else begin
          held = 1; hd = data; ha = addr; hl = last;
        end
      end
      if (done) begin
        dcnt++; dcyc = cyc; fin = 1;
        chk("done_valid_low", valid, 1'b0);
        chk("done_idle", busy, 1'b0);
      end
      @(posedge clk); #1;
      cyc++;
      if (poke && cyc == 2) begin
        start = 1'b1; base_addr = 4'd9; len = 5'd3;
      end else begin
        start = 1'b0;
      end
    end
    we = 1'b0;
    start = 1'b0;
    chk("beat_count", got, n);
    chk("done_count", dcnt, 1);
    if (chk_time) chk("done_cycle", dcyc, (n == 0) ? 1 : n + 2);
    @(negedge clk);
    chk("done_single_pulse", done, 1'b0);
    chk("idle_no_valid", valid, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NW; i++) mem[i] <= 16'h1000 + 16'(i);
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", valid, 0);
    chk("rst_last", last, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_data", data, 0);
    chk("rst_addr", addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed bursts
    run_burst(3, 4, 0, 0, 0, 1);
    run_burst(14, 4, 0, 0, 0, 1);
    run_burst(0, 16, 1, 0, 0, 0);
    run_burst(0, 0, 0, 0, 0, 1);
    run_burst(6, 4, 0, 1, 0, 1);
    run_burst(2, 20, 0, 0, 0, 1);
    run_burst(15, 1, 1, 0, 0, 0);

    // Randomized bursts
    for (int k = 0; k < 12; k++)
      run_burst(int'($urandom_range(0, 15)), int'($urandom_range(0, 20)), 1, 0, 0, 0);

    // Reset mid-burst after two of eight beats
    begin
      int got, cyc;
      bit saw_done;
      got = 0; cyc = 0; saw_done = 0;
      ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b1; base_addr = 4'd0; len = 5'd8;
      @(posedge clk); #1;
      start = 1'b0;
      while (got < 2 && cyc < 50) begin
        @(negedge clk);
        if (valid && ready) got++;
        @(posedge clk); #1;
        cyc++;
      end
      chk("rst_test_two_beats", got, 2);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", valid, 0);
      chk("midrst_last", last, 0);
      chk("midrst_data", data, 0);
      chk("midrst_addr", addr, 0);
      chk("midrst_raddr", raddr, 0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (done) saw_done = 1;
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (done) saw_done = 1;
      end
      chk("midrst_no_done", saw_done, 0);
      run_burst(5, 6, 1, 0, 0, 0);
    end

    // Write to the word being read (addr 5) during a burst
    run_burst(3, 4, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
